// File: rtl/operand_fetch_arbiter.sv
// operand_fetch_arbiter: sequences source-operand fetches from the control unit
// (requester 0) and the debug monitor (requester 1) onto a shared register-file
// read port and the combinational constant table. Only one fetch is in flight.
// Optional feature macro: OPERAND_FETCH_DBG_EN. When it is undefined, requester 1
// is ignored and requester 0 is granted whenever it is valid in IDLE.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req{0,1}_valid/ready/rc/sel        request channels (rc: 0 reg, 1 const)
//   rf_rd_en, rf_addr, rf_data         register-file read port (1-cycle latency)
//   ct_addr, ct_data                   constant-table lookup (combinational)
//   rsp_valid/ready/data/id            response channel
module operand_fetch_arbiter #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_rc,
  input  logic [2:0]           req0_sel,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_rc,
  input  logic [2:0]           req1_sel,
  output logic                 rf_rd_en,
  output logic [2:0]           rf_addr,
  input  logic [WORD_SIZE-1:0] rf_data,
  output logic [2:0]           ct_addr,
  input  logic [WORD_SIZE-1:0] ct_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RF_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       gnt0;
  logic       gnt1;
  logic       gnt_any;
  logic       gnt_rc;
  logic [2:0] gnt_sel;

`ifdef OPERAND_FETCH_DBG_EN
  // Requester granted most recently; resets to 1 so req0 wins first contention.
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt_any) begin
      last_grant <= gnt1;
    end
  end
`else
  logic unused_req1;
  assign unused_req1 = ^{req1_valid, req1_rc, req1_sel};
`endif

  // Grant decode: only in IDLE, and never while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef OPERAND_FETCH_DBG_EN
      gnt0 = req0_valid && (!req1_valid || last_grant);
      gnt1 = req1_valid && (!req0_valid || !last_grant);
`else
      gnt0 = req0_valid;
`endif
    end
  end

  assign gnt_any = gnt0 | gnt1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_next = gnt_rc ? RESP : RF_WAIT;
        end
      end
      RF_WAIT: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: handshake, lookup addresses and response valid.
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
`ifdef OPERAND_FETCH_DBG_EN
    gnt_rc  = gnt1 ? req1_rc  : req0_rc;
    gnt_sel = gnt1 ? req1_sel : req0_sel;
`else
    gnt_rc  = req0_rc;
    gnt_sel = req0_sel;
`endif
    rf_rd_en  = 1'b0;
    rf_addr   = 3'd0;
    ct_addr   = 3'd0;
    rsp_valid = (state == RESP);
    if (gnt_any) begin
      if (gnt_rc) begin
        ct_addr = gnt_sel;
      end else begin
        rf_rd_en = 1'b1;
        rf_addr  = gnt_sel;
      end
    end
  end

  // Response payload: constants captured at grant, register data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else if (gnt_any) begin
      rsp_id <= gnt1;
      if (gnt_rc) begin
        rsp_data <= ct_data;
      end
    end else if (state == RF_WAIT) begin
      rsp_data <= rf_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch_arbiter.sv
// Self-checking bench for operand_fetch_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_operand_fetch_arbiter;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_rc;
  logic [2:0]   req0_sel;
  logic         req1_valid, req1_ready, req1_rc;
  logic [2:0]   req1_sel;
  logic         rf_rd_en;
  logic [2:0]   rf_addr;
  logic [W-1:0] rf_data;
  logic [2:0]   ct_addr;
  logic [W-1:0] ct_data;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ctab [8];
  logic [W-1:0] regs [8];

  operand_fetch_arbiter #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rc(req0_rc), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rc(req1_rc), .req1_sel(req1_sel),
    .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .ct_addr(ct_addr), .ct_data(ct_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  assign ct_data = ctab[ct_addr];

  always @(posedge clk) begin
    if (rf_rd_en) rf_data <= regs[rf_addr];
  end

  task automatic idle_in();
    req0_valid = 1'b0; req0_rc = 1'b0; req0_sel = 3'd0;
    req1_valid = 1'b0; req1_rc = 1'b0; req1_sel = 3'd0;
    rsp_ready  = 1'b1;
  endtask

  task automatic settle();
    idle_in();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); idle_in(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_in();
    req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd5; rsp_ready = 1'b0;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    total++; if ({req0_ready, req1_ready, rf_rd_en} !== 3'b000) begin bad++; $display("FAIL reset_ready_rden got=%b exp=000", {req0_ready, req1_ready, rf_rd_en}); end
    @(negedge clk); rst_n = 1'b1;
    req0_rc = 1'b1; req0_sel = 3'd0; req1_rc = 1'b1; req1_sel = 3'd1; #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL reset_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clk); idle_in(); #1;
    total++; if ({rsp_valid, rsp_id} !== 2'b10) begin bad++; $display("FAIL reset_first_rsp got=%b exp=10", {rsp_valid, rsp_id}); end
    settle();
  endtask

  task automatic test_const_fetch();
    @(negedge clk); idle_in(); req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd6; #1;
    total++; if ({req0_ready, rf_rd_en, ct_addr} !== {2'b10, 3'd6}) begin bad++; $display("FAIL const_handshake got=%b exp=10110", {req0_ready, rf_rd_en, ct_addr}); end
    @(negedge clk); idle_in(); #1;
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 16'h0030}) begin bad++; $display("FAIL const_rsp got v=%b id=%b d=%h exp v=1 id=0 d=0030", rsp_valid, rsp_id, rsp_data); end
    settle();
  endtask

  task automatic test_reg_fetch();
    @(negedge clk); idle_in(); req0_valid = 1'b1; req0_rc = 1'b0; req0_sel = 3'd3; #1;
    total++; if ({req0_ready, rf_rd_en, rf_addr} !== {2'b11, 3'd3}) begin bad++; $display("FAIL reg_handshake got=%b exp=11011", {req0_ready, rf_rd_en, rf_addr}); end
    @(negedge clk); idle_in(); #1;
    total++; if ({rf_rd_en, rsp_valid, req0_ready} !== 3'b000) begin bad++; $display("FAIL reg_wait got=%b exp=000", {rf_rd_en, rsp_valid, req0_ready}); end
    @(negedge clk); #1;
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 16'hBEEF}) begin bad++; $display("FAIL reg_rsp got v=%b id=%b d=%h exp v=1 id=0 d=beef", rsp_valid, rsp_id, rsp_data); end
    settle();
  endtask

`ifdef OPERAND_FETCH_DBG_EN
  task automatic test_contention();
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd7;
      req1_valid = 1'b1; req1_rc = 1'b1; req1_sel = 3'd1; rsp_ready = 1'b1; #1;
      if (k % 2 == 0) begin
        logic g;
        g = ((k / 2) % 2) == 1;
        total++; if ({req0_ready, req1_ready} !== {!g, g}) begin bad++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {!g, g}); end
      end else begin
        logic g;
        logic [W-1:0] d;
        g = ((k / 2) % 2) == 1;
        d = g ? 16'h0001 : 16'hFFFF;
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, g, d}) begin bad++; $display("FAIL contention_rsp k=%0d got v=%b id=%b d=%h exp id=%b d=%h", k, rsp_valid, rsp_id, rsp_data, g, d); end
      end
    end
    settle();
  endtask
`else
  task automatic test_no_dbg();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_rc = 1'b1; req1_sel = 3'd2;
      req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd1; rsp_ready = 1'b1; #1;
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL nodbg_req1_ready k=%0d got=%b exp=0", k, req1_ready); end
      if (k % 2 == 0) begin
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL nodbg_req0_ready k=%0d got=%b exp=1", k, req0_ready); end
      end else begin
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 16'h0001}) begin bad++; $display("FAIL nodbg_rsp k=%0d got v=%b id=%b d=%h exp v=1 id=0 d=0001", k, rsp_valid, rsp_id, rsp_data); end
      end
    end
    settle();
  endtask
`endif

  task automatic test_backpressure();
    @(negedge clk); idle_in(); req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; req1_rc = 1'b1; rsp_ready = 1'b0; #1;
      total++; if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {2'b10, 16'h0008, 2'b00}) begin bad++; $display("FAIL bp_hold k=%0d got v=%b id=%b d=%h r=%b%b", k, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready); end
    end
    settle();
    @(negedge clk); idle_in(); req0_valid = 1'b1; req0_rc = 1'b0; req0_sel = 3'd2;
    @(negedge clk); idle_in(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_midfetch_rsp k=%0d got=%b exp=0", k, rsp_valid); end
    end
    @(negedge clk); req0_valid = 1'b1; req0_rc = 1'b1; req0_sel = 3'd0; #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rst_midfetch_idle got=%b exp=1", req0_ready); end
    settle();
  endtask

  // Transaction-level reference: pending requests per requester, round-robin
  // winner from the last grant, and a response expected 1 (const) or 2 (reg)
  // cycles after its handshake, held until consumed.
  task automatic test_random();
    bit           pv [2];
    bit           prc [2];
    logic [2:0]   psel [2];
    bit           busy, model_last, exp_id, both_ok, ev;
    int           cnt, win;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_ct, exp_rf;
    pulse_reset();
    pv[0] = 0; pv[1] = 0; busy = 0; model_last = 1; cnt = 0; exp_id = 0; exp_data = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1; prc[i] = 1'($urandom); psel[i] = 3'($urandom);
        end
      end
      req0_valid = pv[0]; req0_rc = prc[0]; req0_sel = psel[0];
      req1_valid = pv[1]; req1_rc = prc[1]; req1_sel = psel[1];
      rsp_ready  = ($urandom_range(3, 0) != 0);
      #1;
`ifdef OPERAND_FETCH_DBG_EN
      both_ok = pv[1];
`else
      both_ok = 0;
`endif
      win = -1;
      if (!busy) begin
        if (pv[0] && (!both_ok || model_last)) win = 0;
        else if (both_ok) win = 1;
      end
      exp_ct = (win >= 0 && prc[win]) ? psel[win] : 3'd0;
      exp_rf = (win >= 0 && !prc[win]) ? psel[win] : 3'd0;
      total++; if ({req0_ready, req1_ready} !== {win == 0, win == 1}) begin bad++; $display("FAIL rand_ready c=%0d got=%b%b exp_win=%0d", c, req0_ready, req1_ready, win); end
      total++; if ({rf_rd_en, rf_addr, ct_addr} !== {(win >= 0 && !prc[win]), exp_rf, exp_ct}) begin bad++; $display("FAIL rand_lookup c=%0d got en=%b rf=%0d ct=%0d exp rf=%0d ct=%0d", c, rf_rd_en, rf_addr, ct_addr, exp_rf, exp_ct); end
      ev = busy && (cnt == 0);
      total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rsp_valid, ev); end
      if (ev) begin
        total++; if ({rsp_id, rsp_data} !== {exp_id, exp_data}) begin bad++; $display("FAIL rand_rsp c=%0d got id=%b d=%h exp id=%b d=%h", c, rsp_id, rsp_data, exp_id, exp_data); end
      end
      if (busy) begin
        if (cnt > 0) cnt--;
        else if (rsp_ready) busy = 0;
      end else if (win >= 0) begin
        busy = 1;
        cnt = prc[win] ? 0 : 1;
        exp_data = prc[win] ? ctab[psel[win]] : regs[psel[win]];
        exp_id = (win == 1);
        model_last = (win == 1);
        pv[win] = 0;
      end
    end
    settle();
  endtask

  initial begin
    ctab[0] = 16'h0000; ctab[1] = 16'h0001; ctab[2] = 16'h0002; ctab[3] = 16'h0004;
    ctab[4] = 16'h0008; ctab[5] = 16'h0020; ctab[6] = 16'h0030; ctab[7] = 16'hFFFF;
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    regs[3] = 16'hBEEF;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    test_reset();
    test_const_fetch();
    test_reg_fetch();
`ifdef OPERAND_FETCH_DBG_EN
    test_contention();
`else
    test_no_dbg();
`endif
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
